// File: rtl/mem_port_arbiter_if.sv
// Bundles the two requester ports and the memory-side port of the memory port arbiter.
// The slave modport is the arbiter's view; master is the environment (requesters and memory).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              wr0;
  logic              wr1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              rvalid0;
  logic              rvalid1;
  logic              mem_cs;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              owner;
  logic              busy;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
    output mem_cs, mem_wr, mem_addr, mem_wdata, owner, busy
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
    input  mem_cs, mem_wr, mem_addr, mem_wdata, owner, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for one memory port: combinational grant, read data one cycle after the beat.
// Requesters stall by holding req until gnt; an owner keeps the port at most MAX_BURST beats under contention.
module mem_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int               CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } beat_t;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              last;
  logic              owner_q;
  logic [CNT_W-1:0]  cnt;
  logic              gnt0;
  logic              gnt1;
  logic              beat;
  logic              last_beat;
  beat_t             req_b0;
  beat_t             req_b1;
  beat_t             sel_b;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_wdata;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              rvalid0_q;
  logic              rvalid1_q;

  assign req_b0 = {bus.wr0, bus.addr0, bus.wdata0};
  assign req_b1 = {bus.wr1, bus.addr1, bus.wdata1};
  assign sel_b  = owner_q ? req_b1 : req_b0;

  assign gnt0      = (state == OWN0) & bus.req0;
  assign gnt1      = (state == OWN1) & bus.req1;
  assign beat      = gnt0 | gnt1;
  assign last_beat = (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) state_nxt = last ? OWN0 : OWN1;
        else if (bus.req0)        state_nxt = OWN0;
        else if (bus.req1)        state_nxt = OWN1;
      end
      OWN0: begin
        if (!bus.req0)                  state_nxt = bus.req1 ? OWN1 : IDLE;
        else if (bus.req1 && last_beat) state_nxt = OWN1;
      end
      OWN1: begin
        if (!bus.req1)                  state_nxt = bus.req0 ? OWN0 : IDLE;
        else if (bus.req0 && last_beat) state_nxt = OWN0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last starts at 1 so that port 0 wins the first contention after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      owner_q <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
        if (state_nxt != IDLE) begin
          last    <= (state_nxt == OWN1);
          owner_q <= (state_nxt == OWN1);
        end
      end else if (beat && !last_beat) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Memory address/data keep the last beat's values while no one is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_addr  <= '0;
      hold_wdata <= '0;
    end else if (beat) begin
      hold_addr  <= sel_b.addr;
      hold_wdata <= sel_b.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= gnt0 & ~bus.wr0;
      rvalid1_q <= gnt1 & ~bus.wr1;
      if (gnt0 && !bus.wr0) rdata0_q <= bus.mem_rdata;
      if (gnt1 && !bus.wr1) rdata1_q <= bus.mem_rdata;
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.mem_cs    = ~beat;
  assign bus.mem_wr    = beat & sel_b.wr;
  assign bus.mem_addr  = beat ? sel_b.addr  : hold_addr;
  assign bus.mem_wdata = beat ? sel_b.wdata : hold_wdata;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MAX_BURST=4 main instance plus a MAX_BURST=1 instance for alternation.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus_b ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_BURST(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  // Read data is a fixed function of the address (0x0010 -> 0xA5); writes land in a small array.
  logic [7:0] wmem [0:15];
  assign bus.mem_rdata   = bus.mem_addr[7:0] ^ 8'hB5;
  assign bus_b.mem_rdata = 8'h00;

  always @(posedge clk) begin
    if (!bus.mem_cs && bus.mem_wr) wmem[bus.mem_addr[3:0]] <= bus.mem_wdata;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({bus.gnt0, bus.gnt1, bus.mem_cs, bus.mem_wr, bus.rvalid0, bus.rvalid1, bus.owner, bus.busy} !== 8'b0010_0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00100000", {bus.gnt0, bus.gnt1, bus.mem_cs, bus.mem_wr, bus.rvalid0, bus.rvalid1, bus.owner, bus.busy});
    end
    n_checks++;
    if ({bus.rdata0, bus.rdata1} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h expected 0000", {bus.rdata0, bus.rdata1});
    end
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata} !== 24'h000000) begin
      n_fail++;
      $display("FAIL reset_mem_bus: got %h expected 000000", {bus.mem_addr, bus.mem_wdata});
    end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single_read();
    bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 16'h0010;
    #1;
    n_checks++;
    if ({bus.gnt0, bus.mem_cs} !== 2'b01) begin
      n_fail++; $display("FAIL read_c0_idle: got %b expected 01", {bus.gnt0, bus.mem_cs});
    end
    cyc();
    n_checks++;
    if ({bus.gnt0, bus.mem_cs, bus.mem_wr, bus.rvalid0} !== 4'b1000) begin
      n_fail++; $display("FAIL read_c1_beat: got %b expected 1000", {bus.gnt0, bus.mem_cs, bus.mem_wr, bus.rvalid0});
    end
    n_checks++;
    if (bus.mem_addr !== 16'h0010) begin
      n_fail++; $display("FAIL read_c1_addr: got %h expected 0010", bus.mem_addr);
    end
    cyc();
    bus.req0 = 1'b0; bus.addr0 = 16'h0033;
    #1;
    n_checks++;
    if ({bus.rvalid0, bus.rdata0} !== 9'h1A5) begin
      n_fail++; $display("FAIL read_c2_data: got %h expected 1a5", {bus.rvalid0, bus.rdata0});
    end
    n_checks++;
    if ({bus.gnt0, bus.mem_cs, bus.owner, bus.busy} !== 4'b0101) begin
      n_fail++; $display("FAIL read_c2_withdraw: got %b expected 0101", {bus.gnt0, bus.mem_cs, bus.owner, bus.busy});
    end
    n_checks++;
    if (bus.mem_addr !== 16'h0010) begin
      n_fail++; $display("FAIL read_c2_hold_addr: got %h expected 0010", bus.mem_addr);
    end
    cyc();
    n_checks++;
    if ({bus.rvalid0, bus.rdata0, bus.busy} !== 10'b0_1010_0101_0) begin
      n_fail++; $display("FAIL read_c3_after: got %b expected 0101001010", {bus.rvalid0, bus.rdata0, bus.busy});
    end
  endtask

  // Port 0 owned last, so port 1 goes first; each side gets exactly 4 beats.
  task automatic test_contention();
    logic [1:0] prev_g;
    logic [1:0] exp_g;
    bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 16'h0040;
    bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 16'h0041;
    #1;
    n_checks++;
    if ({bus.gnt1, bus.gnt0} !== 2'b00) begin
      n_fail++; $display("FAIL cont_idle: got %b expected 00", {bus.gnt1, bus.gnt0});
    end
    prev_g = 2'b00;
    for (int i = 0; i < 16; i++) begin
      cyc();
      exp_g = (((i / 4) % 2) == 0) ? 2'b10 : 2'b01;
      n_checks++;
      if ({bus.gnt1, bus.gnt0, bus.mem_cs, bus.rvalid1, bus.rvalid0} !== {exp_g, 1'b0, prev_g}) begin
        n_fail++;
        $display("FAIL cont_cycle%0d: got %b expected %b", i, {bus.gnt1, bus.gnt0, bus.mem_cs, bus.rvalid1, bus.rvalid0}, {exp_g, 1'b0, prev_g});
      end
      n_checks++;
      if (bus.mem_addr !== (exp_g[1] ? 16'h0041 : 16'h0040)) begin
        n_fail++; $display("FAIL cont_addr%0d: got %h expected %h", i, bus.mem_addr, (exp_g[1] ? 16'h0041 : 16'h0040));
      end
      prev_g = exp_g;
    end
    cyc();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    #1;
    n_checks++;
    if ({bus.gnt1, bus.gnt0, bus.mem_cs, bus.owner, bus.busy} !== 5'b00111) begin
      n_fail++; $display("FAIL cont_release: got %b expected 00111", {bus.gnt1, bus.gnt0, bus.mem_cs, bus.owner, bus.busy});
    end
    cyc();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL cont_idle_after: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_rr_first();
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.wr0 = 1'b0; bus.wr1 = 1'b0;
    #1;
    n_checks++;
    if ({bus.gnt1, bus.gnt0} !== 2'b00) begin
      n_fail++; $display("FAIL rr_idle: got %b expected 00", {bus.gnt1, bus.gnt0});
    end
    cyc();
    n_checks++;
    if ({bus.gnt1, bus.gnt0, bus.owner, bus.busy} !== 4'b0101) begin
      n_fail++; $display("FAIL rr_first_grant: got %b expected 0101", {bus.gnt1, bus.gnt0, bus.owner, bus.busy});
    end
  endtask

  // Continues from test_rr_first: port 0 on its first beat, port 1 waiting.
  task automatic test_early_release();
    cyc();
    n_checks++;
    if ({bus.gnt1, bus.gnt0} !== 2'b01) begin
      n_fail++; $display("FAIL early_beat2: got %b expected 01", {bus.gnt1, bus.gnt0});
    end
    cyc();
    bus.req0 = 1'b0;
    #1;
    n_checks++;
    if ({bus.gnt1, bus.gnt0, bus.mem_cs} !== 3'b001) begin
      n_fail++; $display("FAIL early_drop: got %b expected 001", {bus.gnt1, bus.gnt0, bus.mem_cs});
    end
    cyc();
    bus.req0 = 1'b1;
    #1;
    n_checks++;
    if ({bus.gnt1, bus.gnt0, bus.owner} !== 3'b101) begin
      n_fail++; $display("FAIL early_handover: got %b expected 101", {bus.gnt1, bus.gnt0, bus.owner});
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_checks++;
      if ({bus.gnt1, bus.gnt0} !== 2'b10) begin
        n_fail++; $display("FAIL early_p1_beat%0d: got %b expected 10", k + 2, {bus.gnt1, bus.gnt0});
      end
    end
    cyc();
    n_checks++;
    if ({bus.gnt1, bus.gnt0} !== 2'b01) begin
      n_fail++; $display("FAIL early_back_to_p0: got %b expected 01", {bus.gnt1, bus.gnt0});
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    cyc();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL early_idle: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_lone_burst();
    bus.req1 = 1'b1; bus.wr1 = 1'b1; bus.addr1 = 16'h0100; bus.wdata1 = 8'h00;
    #1;
    n_checks++;
    if (bus.gnt1 !== 1'b0) begin
      n_fail++; $display("FAIL burst_idle: got %b expected 0", bus.gnt1);
    end
    for (int k = 0; k < 10; k++) begin
      cyc();
      bus.addr1 = 16'h0100 + 16'(k); bus.wdata1 = 8'(k);
      #1;
      n_checks++;
      if ({bus.gnt1, bus.gnt0, bus.mem_cs, bus.mem_wr, bus.rvalid1} !== 5'b10010) begin
        n_fail++; $display("FAIL burst_ctrl%0d: got %b expected 10010", k, {bus.gnt1, bus.gnt0, bus.mem_cs, bus.mem_wr, bus.rvalid1});
      end
      n_checks++;
      if ({bus.mem_addr, bus.mem_wdata} !== {16'h0100 + 16'(k), 8'(k)}) begin
        n_fail++; $display("FAIL burst_bus%0d: got %h expected %h", k, {bus.mem_addr, bus.mem_wdata}, {16'h0100 + 16'(k), 8'(k)});
      end
    end
    cyc();
    bus.req1 = 1'b0; bus.wr1 = 1'b0;
    #1;
    n_checks++;
    if ({bus.gnt1, bus.mem_cs, bus.rvalid1} !== 3'b010) begin
      n_fail++; $display("FAIL burst_end: got %b expected 010", {bus.gnt1, bus.mem_cs, bus.rvalid1});
    end
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (wmem[k] !== 8'(k)) begin
        n_fail++; $display("FAIL burst_mem%0d: got %h expected %h", k, wmem[k], 8'(k));
      end
    end
    cyc();
  endtask

  task automatic test_reset_mid_burst();
    bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 16'h0022;
    cyc();
    cyc();
    n_checks++;
    if ({bus.gnt1, bus.rvalid1} !== 2'b11) begin
      n_fail++; $display("FAIL rst_pre_beat2: got %b expected 11", {bus.gnt1, bus.rvalid1});
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.gnt0, bus.gnt1, bus.mem_cs, bus.mem_wr, bus.rvalid0, bus.rvalid1, bus.owner, bus.busy} !== 8'b0010_0000) begin
      n_fail++;
      $display("FAIL rst_mid_ctrl: got %b expected 00100000", {bus.gnt0, bus.gnt1, bus.mem_cs, bus.mem_wr, bus.rvalid0, bus.rvalid1, bus.owner, bus.busy});
    end
    n_checks++;
    if ({bus.rdata1, bus.mem_addr} !== 24'h000000) begin
      n_fail++; $display("FAIL rst_mid_data: got %h expected 000000", {bus.rdata1, bus.mem_addr});
    end
    cyc();
    n_checks++;
    if (bus.rvalid1 !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_rvalid: got %b expected 0", bus.rvalid1);
    end
    rst_n = 1'b1;
    bus.req0 = 1'b1; bus.wr0 = 1'b0;
    #1;
    n_checks++;
    if ({bus.gnt1, bus.gnt0} !== 2'b00) begin
      n_fail++; $display("FAIL rst_after_idle: got %b expected 00", {bus.gnt1, bus.gnt0});
    end
    cyc();
    n_checks++;
    if ({bus.gnt1, bus.gnt0} !== 2'b01) begin
      n_fail++; $display("FAIL rst_after_p0_first: got %b expected 01", {bus.gnt1, bus.gnt0});
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    cyc();
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g;
    bus_b.req0 = 1'b1; bus_b.req1 = 1'b1;
    #1;
    n_checks++;
    if ({bus_b.gnt1, bus_b.gnt0} !== 2'b00) begin
      n_fail++; $display("FAIL alt_idle: got %b expected 00", {bus_b.gnt1, bus_b.gnt0});
    end
    for (int i = 0; i < 8; i++) begin
      cyc();
      exp_g = ((i % 2) == 0) ? 2'b01 : 2'b10;
      n_checks++;
      if ({bus_b.gnt1, bus_b.gnt0, bus_b.mem_cs} !== {exp_g, 1'b0}) begin
        n_fail++; $display("FAIL alt_cycle%0d: got %b expected %b", i, {bus_b.gnt1, bus_b.gnt0, bus_b.mem_cs}, {exp_g, 1'b0});
      end
    end
    bus_b.req0 = 1'b0; bus_b.req1 = 1'b0;
    cyc();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.wr0 = 1'b0; bus.wr1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus_b.req0 = 1'b0; bus_b.req1 = 1'b0; bus_b.wr0 = 1'b0; bus_b.wr1 = 1'b0;
    bus_b.addr0 = '0; bus_b.addr1 = '0; bus_b.wdata0 = '0; bus_b.wdata1 = '0;

    test_reset();
    test_single_read();
    test_contention();
    test_rr_first();
    test_early_release();
    test_lone_burst();
    test_reset_mid_burst();
    test_alternate();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
